// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: opcode encoding and flag bit positions shared by the ALU and its bench.
package alu_mc_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_AND = 4'b0010,
        OP_OR  = 4'b0011,
        OP_XOR = 4'b0100,
        OP_CMP = 4'b0101,
        OP_MOV = 4'b0110,
        OP_SLL = 4'b1000,
        OP_SLR = 4'b1001,
        OP_SRL = 4'b1010,
        OP_SRA = 4'b1011,
        OP_MUL = 4'b1100
    } op_e;

    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mc_mul.sv
// alu_mc_mul: iterative unsigned shift-add multiplier, one partial product per clock.
// start_i loads the operands; done_o is high during the WIDTH-th iteration cycle.
module alu_mc_mul #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int CW = $clog2(WIDTH);

    logic               busy_q, busy_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_sum;

    assign acc_sum   = mplier_q[0] ? acc_q + mcand_q : acc_q;
    assign done_o    = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign product_o = acc_sum;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (start_i) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a_i};
            mplier_d = b_i;
        end else if (busy_q) begin
            busy_d   = !done_o;
            cnt_d    = cnt_q + CW'(1);
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: single-cycle ALU with valid/ready handshake and registered result/flags.
// Define ALU_MC_MUL_EN to add the multi-cycle MUL opcode (BUSY state + alu_mc_mul).
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              op,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic [SHW-1:0]          shift_d,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        res,
    output logic [3:0]              szcv
);

    logic [WIDTH-1:0] a_u, b_u;
    logic [WIDTH:0]   sum_w, diff_w;
    logic [SHW-1:0]   msb_idx, lsb_idx;
    logic             shift_zero, sub_v;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v, alu_z;
    logic [3:0]       alu_flags;
    logic             alu_load;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [3:0]       szcv_q, szcv_d;

    assign a_u        = a;
    assign b_u        = b;
    assign sum_w      = {1'b0, a_u} + {1'b0, b_u};
    assign diff_w     = {1'b0, b_u} - {1'b0, a_u};
    assign sub_v      = (a_u[WIDTH-1] != b_u[WIDTH-1]) && (diff_w[WIDTH-1] != b_u[WIDTH-1]);
    assign shift_zero = (shift_d == '0);
    // Position in b of the last bit shifted out: WIDTH-shift_d (left) or shift_d-1 (right).
    assign msb_idx    = SHW'(WIDTH) - shift_d;
    assign lsb_idx    = shift_d - SHW'(1);

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum_w[WIDTH-1:0];
                alu_c   = sum_w[WIDTH];
                alu_v   = (a_u[WIDTH-1] == b_u[WIDTH-1]) && (sum_w[WIDTH-1] != a_u[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff_w[WIDTH-1:0];
                alu_c   = diff_w[WIDTH];
                alu_v   = sub_v;
            end
            OP_CMP: begin
                alu_res = b_u;
                alu_c   = diff_w[WIDTH];
                alu_v   = sub_v;
            end
            OP_AND: alu_res = a_u & b_u;
            OP_OR:  alu_res = a_u | b_u;
            OP_XOR: alu_res = a_u ^ b_u;
            OP_MOV: alu_res = a_u;
            OP_SLL: begin
                alu_res = b_u << shift_d;
                alu_c   = !shift_zero && b_u[msb_idx];
            end
            OP_SLR: begin
                alu_res = (b_u << shift_d) | (b_u >> msb_idx);
                alu_c   = !shift_zero && b_u[msb_idx];
            end
            OP_SRL: begin
                alu_res = b_u >> shift_d;
                alu_c   = !shift_zero && b_u[lsb_idx];
            end
            OP_SRA: begin
                alu_res = $unsigned($signed(b_u) >>> shift_d);
                alu_c   = !shift_zero && b_u[lsb_idx];
            end
            default: alu_res = '0;
        endcase
    end

    assign alu_z = (op == OP_CMP) ? (diff_w[WIDTH-1:0] == '0) : (alu_res == '0);

    always_comb begin
        alu_flags         = '0;
        alu_flags[FLAG_S] = alu_res[WIDTH-1];
        alu_flags[FLAG_Z] = alu_z;
        alu_flags[FLAG_C] = alu_c;
        alu_flags[FLAG_V] = alu_v;
    end

`ifdef ALU_MC_MUL_EN
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]         state_q, state_d;
    logic               accept, mul_start, mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic [3:0]         mul_flags;

    assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (op == OP_MUL);
    assign alu_load  = accept && !mul_start;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mul_start) state_d = ST_BUSY;
            ST_BUSY: if (mul_done)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        mul_flags         = '0;
        mul_flags[FLAG_S] = mul_prod[WIDTH-1];
        mul_flags[FLAG_Z] = (mul_prod[WIDTH-1:0] == '0);
        mul_flags[FLAG_C] = (mul_prod[2*WIDTH-1:WIDTH] != '0);
    end

    alu_mc_mul #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (mul_start),
        .a_i       (a_u),
        .b_i       (b_u),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );
`else
    assign in_ready = !out_valid_q || out_ready;
    assign alu_load = in_valid && in_ready;
`endif

    // A consumed result drops out_valid unless a new result lands on the same edge.
    always_comb begin
        out_valid_d = out_valid_q;
        res_d       = res_q;
        szcv_d      = szcv_q;
        if (out_ready) out_valid_d = 1'b0;
        if (alu_load) begin
            out_valid_d = 1'b1;
            res_d       = alu_res;
            szcv_d      = alu_flags;
        end
`ifdef ALU_MC_MUL_EN
        if (mul_done) begin
            out_valid_d = 1'b1;
            res_d       = mul_prod[WIDTH-1:0];
            szcv_d      = mul_flags;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
            szcv_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            szcv_q      <= szcv_d;
        end
    end

    assign out_valid = out_valid_q;
    assign res       = res_q;
    assign szcv      = szcv_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench for alu_mc (WIDTH=16); MUL checks build with ALU_MC_MUL_EN.
module tb_alu_mc;
    import alu_mc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [3:0]  op = 4'h0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [3:0]  shift_d = '0;
    logic        in_ready, out_valid;
    logic [15:0] res;
    logic [3:0]  szcv;

    logic [19:0] sb[$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_sent   = 0;
    int n_popped = 0;
    bit rnd_ready = 1'b0;

    alu_mc #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .shift_d   (shift_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .szcv      (szcv)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: {res, S, Z, C, V}; shifts are modelled one bit at a time.
    function automatic logic [19:0] model(input logic [3:0] o, input logic [15:0] x,
                                          input logic [15:0] y, input logic [3:0] s);
        logic [15:0] r, d;
        logic [31:0] t;
        logic        c, v, z;
        r = '0; c = 1'b0; v = 1'b0;
        d = y - x;
        t = 32'(x) + 32'(y);
        case (o)
            4'h0: begin r = t[15:0]; c = t[16]; v = (x[15] == y[15]) && (r[15] != x[15]); end
            4'h1: begin r = d; c = (y < x); v = (x[15] != y[15]) && (d[15] != y[15]); end
            4'h2: r = x & y;
            4'h3: r = x | y;
            4'h4: r = x ^ y;
            4'h5: begin r = y; c = (y < x); v = (x[15] != y[15]) && (d[15] != y[15]); end
            4'h6: r = x;
            4'h8: begin r = y; for (int i = 0; i < int'(s); i++) begin c = r[15]; r = {r[14:0], 1'b0}; end end
            4'h9: begin r = y; for (int i = 0; i < int'(s); i++) begin c = r[15]; r = {r[14:0], r[15]}; end end
            4'hA: begin r = y; for (int i = 0; i < int'(s); i++) begin c = r[0]; r = {1'b0, r[15:1]}; end end
            4'hB: begin r = y; for (int i = 0; i < int'(s); i++) begin c = r[0]; r = {r[15], r[15:1]}; end end
`ifdef ALU_MC_MUL_EN
            4'hC: begin t = 32'(x) * 32'(y); r = t[15:0]; c = (t[31:16] != 0); end
`endif
            default: r = '0;
        endcase
        z = (o == 4'h5) ? (d == 0) : (r == 0);
        return {r, r[15], z, c, v};
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                logic [19:0] e;
                check("sb_pending", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    n_popped++;
                    check("res", 32'(res), 32'(e[19:4]));
                    check("szcv", 32'(szcv), 32'(e[3:0]));
                end
            end
            if (in_valid && in_ready) sb.push_back(model(op, a, b, shift_d));
        end
    end

    task automatic drive(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                         input logic [3:0] s);
        op = o; a = x; b = y; shift_d = s; in_valid = 1'b1;
        n_sent++;
    endtask

    task automatic wait_accept(output int waits);
        logic ok;
        ok = 1'b0;
        waits = 0;
        while (!ok && waits < 64) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (!ok) begin
                waits++;
                if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            end
        end
        check("accept", 32'(ok), 32'd1);
    endtask

    task automatic send(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                        input logic [3:0] s, output int waits);
        drive(o, x, y, s);
        wait_accept(waits);
    endtask

    // Full-throughput send: with out_ready high every request must go in without a wait.
    task automatic dsend(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                         input logic [3:0] s);
        int w;
        send(o, x, y, s, w);
        check("b2b_wait", 32'(w), 32'd0);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    initial begin
        int w, n;
        bit seen;
        logic [19:0] e;

        repeat (3) @(posedge clk);
        #1;
        check("rst_vld", 32'(out_valid), 32'd0);
        check("rst_res", 32'(res), 32'd0);
        check("rst_szcv", 32'(szcv), 32'd0);
        check("rst_rdy", 32'(in_ready), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        dsend(OP_ADD, 16'h7FFF, 16'h0001, 4'd0);
        dsend(OP_ADD, 16'hFFFF, 16'h0001, 4'd0);
        dsend(OP_SUB, 16'd5, 16'd3, 4'd0);
        dsend(OP_SUB, 16'h0001, 16'h8000, 4'd0);
        dsend(OP_CMP, 16'd3, 16'd3, 4'd0);
        dsend(OP_CMP, 16'h0010, 16'h0020, 4'd0);
        dsend(OP_AND, 16'hF0F0, 16'h3C3C, 4'd0);
        dsend(OP_OR,  16'hF000, 16'h000F, 4'd0);
        dsend(OP_XOR, 16'hAAAA, 16'hAAAA, 4'd0);
        dsend(OP_MOV, 16'h8123, 16'h0000, 4'd0);
        dsend(OP_SLL, 16'h0000, 16'h8001, 4'd0);
        dsend(OP_SLL, 16'h0000, 16'h1234, 4'd4);
        dsend(OP_SLL, 16'h0000, 16'h0003, 4'd15);
        dsend(OP_SLR, 16'h0000, 16'h8001, 4'd1);
        dsend(OP_SLR, 16'h0000, 16'h1234, 4'd0);
        dsend(OP_SLR, 16'h0000, 16'hF00F, 4'd8);
        dsend(OP_SRL, 16'h0000, 16'h8001, 4'd1);
        dsend(OP_SRL, 16'h0000, 16'hC000, 4'd15);
        dsend(OP_SRA, 16'h0000, 16'h8000, 4'd15);
        dsend(OP_SRA, 16'h0000, 16'h7FF8, 4'd4);
        dsend(OP_SRA, 16'h0000, 16'h8001, 4'd0);
        dsend(4'h7, 16'h1234, 16'h5678, 4'd3);
        dsend(4'hF, 16'hFFFF, 16'hFFFF, 4'd1);
`ifndef ALU_MC_MUL_EN
        dsend(4'hC, 16'd300, 16'd300, 4'd0);
`endif
        idle();
        repeat (2) @(posedge clk);
        #1;

        // Output stall: three cycles of back-pressure with a second request waiting.
        out_ready = 1'b0;
        send(OP_ADD, 16'd100, 16'd23, 4'd0, w);
        drive(OP_XOR, 16'h00FF, 16'h0F0F, 4'd0);
        e = model(OP_ADD, 16'd100, 16'd23, 4'd0);
        repeat (3) begin
            @(negedge clk);
            check("stall_rdy", 32'(in_ready), 32'd0);
            check("stall_vld", 32'(out_valid), 32'd1);
            check("stall_res", 32'(res), 32'(e[19:4]));
            check("stall_szcv", 32'(szcv), 32'(e[3:0]));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_accept(w);
        dsend(OP_SUB, 16'd7, 16'd2, 4'd0);
        idle();
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset mid-cycle with a held result.
        out_ready = 1'b0;
        send(OP_ADD, 16'd1, 16'd2, 4'd0, w);
        idle();
        #2 rst_n = 1'b0;
        #1;
        check("arst_vld", 32'(out_valid), 32'd0);
        check("arst_res", 32'(res), 32'd0);
        check("arst_szcv", 32'(szcv), 32'd0);
        check("arst_rdy", 32'(in_ready), 32'd1);
        check("arst_pending", 32'(sb.size()), 32'd1);
        n_sent -= sb.size();
        sb.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

`ifdef ALU_MC_MUL_EN
        send(OP_MUL, 16'd300, 16'd300, 4'd0, w);
        idle();
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid) seen = 1'b1;
            else check("busy_rdy", 32'(in_ready), 32'd0);
        end
        check("mul_lat", 32'(n), 32'd16);
        send(OP_MUL, 16'd7, 16'd9, 4'd0, w);
        send(OP_MUL, 16'h0000, 16'hBEEF, 4'd0, w);
        send(OP_MUL, 16'hFFFF, 16'hFFFF, 4'd0, w);
        dsend(OP_ADD, 16'd1, 16'd1, 4'd0);
        idle();
        repeat (2) @(posedge clk);
        #1;

        // Reset during the fifth iteration must abort the multiply silently.
        send(OP_MUL, 16'd300, 16'd300, 4'd0, w);
        idle();
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_vld", 32'(out_valid), 32'd0);
        check("abort_rdy_rst", 32'(in_ready), 32'd1);
        check("abort_pending", 32'(sb.size()), 32'd1);
        n_sent -= sb.size();
        sb.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_rdy", 32'(in_ready), 32'd1);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("abort_quiet", 32'(seen), 32'd0);
        @(posedge clk);
        #1;
`endif

        rnd_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            send(4'($urandom_range(0, 15)), 16'($urandom()), 16'($urandom()),
                 4'($urandom_range(0, 15)), w);
        end
        idle();
        rnd_ready = 1'b0;
        out_ready = 1'b1;

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("n_results", 32'(n_popped), 32'(n_sent));
        check("final_vld", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the operand/result width in bits (legal: 8, 16, 32).
REQ-002 Parameter SHW, default $clog2(WIDTH), SHALL set the shift-amount width (derived; not overridden).
REQ-003 clk  input  1  SHALL be the single rising-edge clock.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 in_valid  input  1  SHALL mark a valid request.
REQ-006 in_ready  output  1  SHALL mean the request is accepted this cycle.
REQ-007 op  input  4  SHALL carry the opcode.
REQ-008 a, b  input  WIDTH each, signed  SHALL carry the operands.
REQ-009 shift_d  input  SHW  SHALL carry the shift amount.
REQ-010 out_valid  output  1  SHALL mark a valid result.
REQ-011 out_ready  input  1  SHALL mean the consumer takes the result.
REQ-012 res  output  WIDTH  SHALL carry the result.
REQ-013 szcv  output  4  SHALL carry the flags: [3]=S, [2]=Z, [1]=C, [0]=V.

Function
REQ-014 Opcodes SHALL be:
- 0000 ADD: a+b
- 0001 SUB: b-a
- 0010 AND
- 0011 OR
- 0100 XOR
- 0101 CMP: res=b, flags of b-a
- 0110 MOV: res=a
- 1000 SLL
- 1001 SLR: rotate left by shift_d
- 1010 SRL
- 1011 SRA
- 1100 MUL (see Configuration)
REQ-015 A request SHALL be accepted on any edge where in_valid and in_ready are both high; in_ready = (state==IDLE) and (!out_valid or out_ready).
REQ-016 A non-MUL op SHALL register res/szcv and set out_valid on the acceptance edge (latency 1 cycle); back-to-back acceptance SHALL sustain 1 op/cycle.
REQ-017 res and szcv SHALL hold stable while out_valid and !out_ready; out_valid SHALL fall on the edge where out_ready is high unless a new result is loaded.
REQ-018 The state machine SHALL have states IDLE and BUSY (MUL only): IDLE->BUSY on MUL acceptance, BUSY->IDLE on the WIDTH-th iteration edge.
REQ-019 S SHALL equal res[WIDTH-1]; Z SHALL be 1 iff res==0 (CMP: iff b-a==0).
REQ-020 C SHALL be set as follows:
- ADD: carry out
- SUB/CMP: borrow (b<a unsigned)
- SLL/SLR: last bit shifted out, b[WIDTH-shift_d]
- SRL/SRA: b[shift_d-1]
- shift_d==0: C=0
- logic/MOV: C=0
REQ-021 V SHALL be set as follows:
- ADD: (a[W-1]==b[W-1]) & (res[W-1]!=a[W-1])
- SUB/CMP: (a[W-1]!=b[W-1]) & (diff[W-1]!=b[W-1])
- all other ops: V=0
REQ-022 shift_d==0 SHALL return b unchanged for all shift ops; SRA SHALL sign-fill.
REQ-023 An undefined opcode SHALL complete in 1 cycle with res=0, szcv=4'b0100.

Reset
REQ-024 While rst_n is low, state SHALL be IDLE, and out_valid, res, szcv and the iteration counter SHALL be 0, regardless of clk.
REQ-025 rst_n asserted mid-MUL SHALL abort the operation with no result emitted; in_ready SHALL be 1 on the first edge after release.

Configuration
REQ-026 With ALU_MC_MUL_EN defined, MUL SHALL compute the low WIDTH bits of unsigned a*b by iterative shift-add:
- latency: out_valid rises WIDTH edges after the acceptance edge
- in_ready=0 while BUSY
- C=1 iff the high half is nonzero
- S/Z per REQ-019, V=0
REQ-027 Without ALU_MC_MUL_EN, opcode 1100 SHALL behave as an undefined opcode (REQ-023), and no multiplier logic or BUSY state SHALL be synthesised.

Structure
REQ-028 Package alu_mc_pkg SHALL hold the opcode enum and the flag index constants (FLAG_S/Z/C/V).
REQ-029 The iterative multiplier SHALL be sub-module alu_mc_mul (start/done, WIDTH-parametrised), instantiated only under ALU_MC_MUL_EN.

Verification
REQ-030 WIDTH=16, ADD a=16'h7FFF, b=16'h0001 -> next cycle res=16'h8000, szcv=4'b1001.
REQ-031 SUB a=5, b=3 -> res=16'hFFFE, szcv=4'b1010; CMP a=3, b=3 -> res=3, szcv=4'b0100.
REQ-032 SLR b=16'h8001, shift_d=1 -> res=16'h0003, C=1; SRA b=16'h8000, shift_d=15 -> res=16'hFFFF, C=0.
REQ-033 Back-to-back requests with out_ready held low for 3 cycles -> first result holds stable, in_ready=0, no request lost, results in order.
REQ-034 ALU_MC_MUL_EN, MUL a=300, b=300 -> out_valid exactly 16 edges after acceptance, res=16'h5F90, C=1; rst_n pulsed at iteration 5 -> no out_valid, in_ready=1 after release.
